// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared bank of 1-bit enable-gated cells.
// The winner's word is shadowed, then loaded LSB first, one cell per cycle.
module reg_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         grant,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   cell_en,
  output logic               cell_din,
  output logic               busy,
  output logic [1:0]         last_owner
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       ack_q, ack_d;

  logic [WIDTH-1:0] words [4];
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             win_vld;
  logic             last_bit;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      words[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Scan from the highest offset down so the bit nearest ptr wins.
  always_comb begin
    win     = ptr_q;
    idx     = ptr_q;
    win_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign last_bit = (bitcnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    last_d   = last_q;
    bitcnt_d = bitcnt_q;
    shadow_d = shadow_q;
    grant_d  = grant_q;
    ack_d    = 4'd0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = WRITE;
          owner_d  = win;
          grant_d  = 4'd1 << win;
          shadow_d = words[win];
          bitcnt_d = '0;
        end
      end
      WRITE: begin
        bitcnt_d = bitcnt_q + CW'(1);
        if (last_bit) begin
          state_d  = DONE;
          bitcnt_d = '0;
          grant_d  = 4'd0;
          ack_d    = 4'd1 << owner_q;
          last_d   = owner_q;
          ptr_d    = owner_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      last_q   <= 2'd0;
      bitcnt_q <= '0;
      shadow_q <= '0;
      grant_q  <= 4'd0;
      ack_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      bitcnt_q <= bitcnt_d;
      shadow_q <= shadow_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign last_owner = last_q;
  assign busy       = (state_q != IDLE);
  assign cell_en    = (state_q == WRITE)
                    ? (WIDTH'(1) << bitcnt_q) : '0;
  assign cell_din   = (state_q == WRITE) & shadow_q[bitcnt_q];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: transfer-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reg_write_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req = 4'd0;
  logic [4*W-1:0] wdata = '0;
  logic [3:0]   grant, ack;
  logic [W-1:0] cell_en;
  logic         cell_din, busy;
  logic [1:0]   last_owner;

  logic [W-1:0] bank = '0;

  int n_vec = 0;
  int n_bad = 0;
  int pc = 0;
  int p0 = 0;

  reg_write_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .wdata      (wdata),
    .grant      (grant),
    .ack        (ack),
    .cell_en    (cell_en),
    .cell_din   (cell_din),
    .busy       (busy),
    .last_owner (last_owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pc++;

  // The shared bank: plain enable-gated D cells, never reset.
  always @(posedge clk) begin
    for (int b = 0; b < W; b++) begin
      if (cell_en[b]) bank[b] <= cell_din;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, pc);
    end
  endtask

  // Model: m_t counts cycles into a transfer
  // (0 idle, 1..W writing bit m_t-1, W+1 ack cycle).
  int           m_t = 0;
  int           m_k = 0;
  int           m_ptr = 0;
  int           m_last = 0;
  logic [W-1:0] m_word = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_k = 0; m_ptr = 0; m_last = 0; m_word = '0;
    end else if (m_t == 0) begin
      if (req != 4'd0) begin
        for (int i = 3; i >= 0; i--)
          if (req[(m_ptr + i) % 4]) m_k = (m_ptr + i) % 4;
        m_word = wdata[m_k*W +: W];
        m_t = 1;
      end
    end else if (m_t == W + 1) begin
      m_t = 0;
    end else begin
      m_t++;
      if (m_t == W + 1) begin
        m_last = m_k;
        m_ptr = (m_k + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0]   eg, ea;
    logic [W-1:0] ee;
    logic         ed;
    bit           wr;
    wr = (m_t >= 1 && m_t <= W);
    eg = wr ? 4'(1 << m_k) : 4'd0;
    ea = (m_t == W + 1) ? 4'(1 << m_k) : 4'd0;
    ee = wr ? W'(1 << (m_t - 1)) : '0;
    ed = wr ? m_word[m_t-1] : 1'b0;
    chk("grant", 32'(grant), 32'(eg));
    chk("ack", 32'(ack), 32'(ea));
    chk("cell_en", 32'(cell_en), 32'(ee));
    chk("cell_din", 32'(cell_din), 32'(ed));
    chk("busy", 32'(busy), 32'(m_t != 0));
    if (m_t != W + 1)
      chk("last_owner", 32'(last_owner), 32'(m_last));
    chk("onehot", 32'({$countones(grant) <= 1,
                       $countones(ack) <= 1,
                       $countones(cell_en) <= 1}), 32'd7);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_any_ack(output int k, output int dc);
    k = -1;
    dc = -1;
    for (int n = 0; n < 80; n++) begin
      step();
      if (ack != 4'd0) begin
        for (int i = 0; i < 4; i++) if (ack[i]) k = i;
        dc = pc - p0;
        break;
      end
    end
    if (k < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_timeout: got none expected an ack (cycle %0d)", pc);
    end else begin
      req[k] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dc;
    logic [W-1:0] seq;
    int order [4];
    int cyc [4];

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cell_en", 32'(cell_en), 32'd0);
    chk("rst_last", 32'(last_owner), 32'd0);
    rst_n = 1'b1;
    step();

    // Single request
    wdata[0 +: W] = 8'hA5;
    req = 4'b0001;
    p0 = pc;
    seq = '0;
    for (int c = 1; c <= W; c++) begin
      step();
      seq[c-1] = cell_din;
      chk("t1_walk", 32'(cell_en), 32'(1 << (c - 1)));
      chk("t1_grant", 32'(grant), 32'd1);
    end
    step();
    chk("t1_ack", 32'(ack), 32'd1);
    chk("t1_ack_cycle", pc - p0, 32'd9);
    req = 4'd0;
    step();
    chk("t1_seq", 32'(seq), 32'hA5);
    chk("t1_bank", 32'(bank), 32'hA5);
    chk("t1_last", 32'(last_owner), 32'd0);

    // Contention from reset
    rst_n = 1'b0;
    wdata = {8'h88, 8'h44, 8'h22, 8'h11};
    req = 4'b1111;
    step(2);
    rst_n = 1'b1;
    p0 = pc;
    for (int j = 0; j < 4; j++) begin
      wait_any_ack(k, dc);
      order[j] = k;
      cyc[j] = dc;
    end
    step();
    for (int j = 0; j < 4; j++) begin
      chk("t2_order", 32'(order[j]), 32'(j));
      chk("t2_cycle", 32'(cyc[j]), 32'(9 + 10 * j));
    end
    chk("t2_bank", 32'(bank), 32'h88);

    // Round-robin rotation: ack to 2, then 0101
    req = 4'b0100;
    p0 = pc;
    wait_any_ack(k, dc);
    chk("t3_first", 32'(k), 32'd2);
    step();
    req = 4'b0101;
    p0 = pc;
    wait_any_ack(k, dc);
    chk("t3_wrap", 32'(k), 32'd0);
    chk("t3_wrap_cycle", 32'(dc), 32'd9);
    wait_any_ack(k, dc);
    chk("t3_next", 32'(k), 32'd2);
    step();
    chk("t3_bank", 32'(bank), 32'h44);
    chk("t3_last", 32'(last_owner), 32'd2);

    // Data stability
    wdata[W +: W] = 8'h3C;
    req = 4'b0010;
    p0 = pc;
    step(3);
    wdata[W +: W] = 8'hFF;
    wait_any_ack(k, dc);
    chk("t4_k", 32'(k), 32'd1);
    chk("t4_cycle", 32'(dc), 32'd9);
    step();
    chk("t4_bank", 32'(bank), 32'h3C);

    // Early req drop
    wdata[2*W +: W] = 8'h5A;
    req = 4'b0100;
    p0 = pc;
    step(2);
    req = 4'd0;
    wait_any_ack(k, dc);
    chk("t5_k", 32'(k), 32'd2);
    chk("t5_cycle", 32'(dc), 32'd9);
    step(12);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_nogrant", 32'(grant), 32'd0);
    chk("t5_bank", 32'(bank), 32'h5A);

    // Reset mid-transfer over a cleared bank
    wdata[0 +: W] = 8'h00;
    req = 4'b0001;
    p0 = pc;
    wait_any_ack(k, dc);
    step();
    chk("t6_clear", 32'(bank), 32'h00);
    wdata[0 +: W] = 8'hFF;
    req = 4'b0001;
    p0 = pc;
    step(5);
    rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_cell_en", 32'(cell_en), 32'd0);
    chk("t6_din", 32'(cell_din), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ack", 32'(ack), 32'd0);
    req = 4'd0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("t6_bank", 32'(bank), 32'h0F);
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_last", 32'(last_owner), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one WIDTH-bit register bank among 4 requesters. The bank is built from 1-bit enable-gated D cells (posedge clk, en, din, dout).
- Arbitrates write requests round-robin and latches the winner's word.
- Sequences a bit-serial load: one cell enable per cycle, with a shared serial data line driving all cells.
- Pulses an ack to the winner when its word is fully written.

Parameters:
- WIDTH, 8, number of 1-bit cells in the bank (word width); legal range 2..32.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  4  per-requester write request; level, held until its ack
- wdata  input  4*WIDTH  packed write words; requester i uses bits [i*WIDTH +: WIDTH]
- grant  output  4  one-hot owner of the bank, high for the whole transfer
- ack  output  4  one-cycle pulse to the owner on transfer completion
- cell_en  output  WIDTH  one-hot cell enable; bit b enables cell b
- cell_din  output  1  serial data bit, wired to din of every cell
- busy  output  1  high whenever state is not IDLE
- last_owner  output  2  index of the most recently acked requester

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, grant=0, ack=0, cell_en=0, cell_din=0, busy=0, last_owner=0, ptr=0, bitcnt=0, shadow=0.
  - Cells themselves are not reset and keep their contents.
- All outputs are registered or decoded from registered state only. There is no combinational path from req or wdata to any output.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - If req==0, stay.
  - Otherwise, select winner k = first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: state=WRITE, grant=onehot(k), shadow=wdata[k], bitcnt=0.
- WRITE:
  - cell_en = 1<<bitcnt and cell_din = shadow[bitcnt], asserted together in the same cycle.
  - bitcnt increments each cycle.
  - After the cycle with bitcnt==WIDTH-1, go to DONE.
  - Each cell therefore captures exactly one bit, LSB first.
- DONE (one cycle):
  - ack[k]=1, grant=0, cell_en=0.
  - last_owner=k, ptr=(k+1) mod 4; next state IDLE.
- Latency: req sampled in IDLE at cycle 0 → WRITE cycles 1..WIDTH → ack at cycle WIDTH+1 → IDLE at WIDTH+2.
  - Back-to-back transfers issue a new grant at cycle WIDTH+3 at the earliest.
- Shadow capture:
  - wdata is sampled only on the IDLE→WRITE transition.
  - Later wdata changes do not affect the transfer in progress.
- req deasserted mid-transfer: the transfer still completes and ack is still pulsed. There is no abort.
- req still high after ack: treated as a new request, subject to rotated priority. The requester must drop req the cycle after ack to avoid a repeat write.
- Simultaneous requests: exactly one grant. Others wait; the round-robin pointer guarantees each waits at most 3 transfers.
- Pointer wrap: ptr 3→0.
- Reset mid-transfer:
  - Abort immediately; no ack is issued and grant drops.
  - Cells written so far keep new bits, the rest keep old bits. The owner must re-request.
- One-hot invariants: grant, ack and cell_en are each never multi-hot. cell_en is 0 outside WRITE.

Test Plan:
- Single request: WIDTH=8, req=0001, wdata[0]=8'hA5 → grant=0001 for 8 cycles; cell_en walks 01→80; cell_din sequence 1,0,1,0,0,1,0,1; ack=0001 at cycle 9; bank reads 8'hA5; last_owner=0.
- Contention: req=1111 held from reset, each dropped on its ack → grant order 0,1,2,3 with acks at cycles 9, 19, 29, 39; final bank equals wdata[3].
- Round-robin rotation: after an ack to requester 2, req=0101 → requester 0 wins (ptr=3 wraps to 0); then requester 2.
- Data stability: change wdata[1] from 8'h3C to 8'hFF at cycle 3 of a transfer → bank holds 8'h3C; ack pulses normally.
- Reset mid-operation: assert rst_n=0 at cycle 4 of a 8'hFF write over a bank of 8'h00 → all outputs 0 immediately; no ack; bank=8'h0F (4 bits written); FSM in IDLE on release.
- Early req drop: req[2] falls at cycle 2 → transfer completes; ack[2] pulses at cycle 9; no re-grant afterwards.
